// File: rtl/fetch_pkg.sv
// Shared types for the RV32 instruction-fetch stage: FSM states, buffer entry and NOP constant.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD,
    HALT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t; flush wins over push, push into a full
// buffer is accepted only when a pop frees a slot in the same cycle.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch stage: PC, single-outstanding imem handshake, redirect flush and instruction buffer.
// Optional macro FETCH_MISALIGN_CHECK_EN enables misaligned-redirect fault and HALT state.
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, next_state;
  logic [31:0]   pc, pc_next;
  logic [31:0]   req_pc, req_pc_next;
  logic          push, flush, pop, grant, outstanding;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata, fifo_rdata;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault, fault_next, misaligned;

  always_ff @(posedge clk) begin
    if (!reset) fault <= 1'b0;
    else        fault <= fault_next;
  end

  assign fetch_fault = fault;
`else
  assign fetch_fault = 1'b0;
`endif

  // Request is a function of registered state only; reset gating keeps it low while held in reset.
  assign imem_req  = reset && (state == FETCH) && (fifo_count < CW'(DEPTH));
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign dec_valid = !fifo_empty;
  assign dec_instr = fifo_empty ? NOP_INSTR : fifo_rdata.instr;
  assign dec_pc    = fifo_empty ? '0 : fifo_rdata.pc;
  assign pop       = dec_valid && dec_ready;

  assign fifo_wdata = '{pc: req_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= next_state;
      pc     <= pc_next;
      req_pc <= req_pc_next;
    end
  end

  always_comb begin
    next_state  = state;
    pc_next     = pc;
    req_pc_next = req_pc;
    push        = 1'b0;
    flush       = 1'b0;
    outstanding = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_next  = fault;
    misaligned  = 1'b0;
`endif

    case (state)
      FETCH: begin
        if (grant) begin
          req_pc_next = pc;
          pc_next     = pc + 32'd4;
          next_state  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push       = !fifo_full || pop;
          next_state = FETCH;
        end
      end
      DISCARD: begin
        if (imem_rvalid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          next_state = fault ? HALT : FETCH;
`else
          next_state = FETCH;
`endif
        end
      end
      HALT: begin
        next_state = HALT;
      end
      default: next_state = FETCH;
    endcase

    if (redirect_valid) begin
      flush   = 1'b1;
      push    = 1'b0;
      pc_next = redirect_pc & ~32'h3;
      // A response arriving in the redirect cycle already retires the stale fetch.
      outstanding = grant || (((state == WAIT) || (state == DISCARD)) && !imem_rvalid);
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned = |redirect_pc[1:0];
      fault_next = misaligned;
      next_state = outstanding ? DISCARD : (misaligned ? HALT : FETCH);
`else
      next_state = outstanding ? DISCARD : FETCH;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, zero-wait streaming, back-pressure,
// redirects (idle, WAIT, same-cycle grant), reset during WAIT, misaligned redirect handling.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_fail = 0;
  bit mem_auto = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_0013;
  endfunction

  // One clock: sample handshake mid-cycle, advance, then play zero-wait memory if enabled.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    @(negedge clk);
    g = imem_req & imem_gnt;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      imem_gnt    = 1'b1;
      imem_rvalid = g;
      imem_rdata  = g ? instr_of(a) : '0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_auto = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_reset(input bit auto_mem);
    reset = 1'b1; mem_auto = auto_mem; imem_gnt = auto_mem;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_cmp++;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    n_cmp++;
    if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    n_cmp++;
    if (dec_instr !== NOP) begin n_fail++; $display("FAIL reset_dec_instr: got %h expected %h", dec_instr, NOP); end
    n_cmp++;
    if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_dec_pc: got %h expected 00000000", dec_pc); end
    n_cmp++;
    if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    n_cmp++;
  endtask

  task automatic test_zero_wait();
    logic        ev;
    logic [31:0] epc;
    do_reset();
    dec_ready = 1'b1;
    release_reset(1'b1);
    for (int k = 0; k < 7; k++) begin
      ev  = (k >= 2) && (k % 2 == 0);
      epc = ev ? 32'((k - 2) * 2) : 32'h0;
      if (imem_req !== (k % 2 == 0)) begin n_fail++; $display("FAIL zw_req c%0d: got %b expected %b", k, imem_req, (k % 2 == 0)); end
      n_cmp++;
      if (k % 2 == 0) begin
        if (imem_addr !== 32'(k * 2)) begin n_fail++; $display("FAIL zw_addr c%0d: got %h expected %h", k, imem_addr, 32'(k * 2)); end
        n_cmp++;
      end
      if (dec_valid !== ev) begin n_fail++; $display("FAIL zw_valid c%0d: got %b expected %b", k, dec_valid, ev); end
      n_cmp++;
      if (dec_pc !== epc) begin n_fail++; $display("FAIL zw_pc c%0d: got %h expected %h", k, dec_pc, epc); end
      n_cmp++;
      if (dec_instr !== (ev ? instr_of(epc) : NOP)) begin
        n_fail++; $display("FAIL zw_instr c%0d: got %h expected %h", k, dec_instr, ev ? instr_of(epc) : NOP);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    release_reset(1'b1);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 4; k < 7; k++) begin
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full c%0d: got %b expected 0", k, imem_req); end
      n_cmp++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
        n_fail++; $display("FAIL bp_head c%0d: got valid %b pc %h expected valid 1 pc 00000000", k, dec_valid, dec_pc);
      end
      n_cmp++;
      if (k == 6) dec_ready = 1'b1;
      tick();
    end
    dec_ready = 1'b0;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_fail++; $display("FAIL bp_resume: got req %b addr %h expected req 1 addr 00000008", imem_req, imem_addr);
    end
    n_cmp++;
    if (dec_pc !== 32'h4 || dec_instr !== instr_of(32'h4)) begin
      n_fail++; $display("FAIL bp_next_head: got pc %h instr %h expected pc 00000004 instr %h", dec_pc, dec_instr, instr_of(32'h4));
    end
    n_cmp++;
  endtask

  task automatic test_redirect_idle();
    do_reset();
    release_reset(1'b1);
    tick();
    tick();
    mem_auto = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL ri_buffered: got %b expected 1", dec_valid); end
    n_cmp++;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      n_fail++; $display("FAIL ri_target: got req %b addr %h expected req 1 addr 00000300", imem_req, imem_addr);
    end
    n_cmp++;
    if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL ri_flush: got %b expected 0", dec_valid); end
    n_cmp++;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    dec_ready = 1'b1;
    release_reset(1'b0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_discard_req: got %b expected 0", imem_req); end
    n_cmp++;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    if (dec_valid !== 1'b0 || dec_instr !== NOP) begin
      n_fail++; $display("FAIL rw_stale_dropped: got valid %b instr %h expected valid 0 instr %h", dec_valid, dec_instr, NOP);
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL rw_target_req: got req %b addr %h expected req 1 addr 00000100", imem_req, imem_addr);
    end
    n_cmp++;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    if (dec_instr === 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_stale_seen: got %h expected not deadbeef", dec_instr); end
    n_cmp++;
    tick();
    imem_rvalid = 1'b0;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== 32'h00A0_0093) begin
      n_fail++; $display("FAIL rw_new_head: got valid %b pc %h instr %h expected 1 00000100 00a00093", dec_valid, dec_pc, dec_instr);
    end
    n_cmp++;
  endtask

  task automatic test_redirect_on_grant();
    do_reset();
    dec_ready = 1'b1;
    release_reset(1'b0);
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0240;
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    if (imem_req !== 1'b0 || imem_addr !== 32'h240) begin
      n_fail++; $display("FAIL rg_discard: got req %b addr %h expected req 0 addr 00000240", imem_req, imem_addr);
    end
    n_cmp++;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    if (imem_req !== 1'b1 || imem_addr !== 32'h240 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL rg_refetch: got req %b addr %h valid %b expected 1 00000240 0", imem_req, imem_addr, dec_valid);
    end
    n_cmp++;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_rvalid = 1'b0;
    if (dec_pc !== 32'h240 || dec_instr !== 32'h2222_2222) begin
      n_fail++; $display("FAIL rg_head: got pc %h instr %h expected 00000240 22222222", dec_pc, dec_instr);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dec_ready = 1'b1;
    release_reset(1'b0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset = 1'b0;
    #1;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_in_reset: got %b expected 0", imem_req); end
    n_cmp++;
    tick();
    reset = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rm_first_req: got req %b addr %h expected 1 00000000", imem_req, imem_addr);
    end
    n_cmp++;
    tick();
    imem_rvalid = 1'b0;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rm_ignored: got valid %b req %b addr %h expected 0 1 00000000", dec_valid, imem_req, imem_addr);
    end
    n_cmp++;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    imem_rvalid = 1'b0;
    if (dec_pc !== 32'h0 || dec_instr !== 32'h3333_3333 || dec_valid !== 1'b1) begin
      n_fail++; $display("FAIL rm_head: got valid %b pc %h instr %h expected 1 00000000 33333333", dec_valid, dec_pc, dec_instr);
    end
    n_cmp++;
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset();
    release_reset(1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0; imem_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL ma_halt c%0d: got fault %b req %b expected 1 0", k, fetch_fault, imem_req);
      end
      n_cmp++;
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; imem_gnt = 1'b0;
    tick();
    redirect_valid = 1'b0;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL ma_clear: got fault %b req %b addr %h expected 0 1 00000200", fetch_fault, imem_req, imem_addr);
    end
    n_cmp++;
  endtask
`else
  task automatic test_misalign();
    do_reset();
    release_reset(1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL ma_force_align: got fault %b req %b addr %h expected 0 1 00000100", fetch_fault, imem_req, imem_addr);
    end
    n_cmp++;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_on_grant();
    test_reset_mid_wait();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
